// File: rtl/data_mem_responder_if.sv
// Load/store request and response bundle between the RV32I core and data_mem_responder.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, byte-lane stores, right-aligned loads, wait states.
// Optional DMEM_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into errors instead of aligning them.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);
  localparam int unsigned AW  = $clog2(DEPTH_WORDS);
  localparam int unsigned BAW = AW + 2;
  localparam int unsigned CW  = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BAW-1:0]  addr_q, addr_d;
  logic [1:0]      size_q, size_d;
  logic            we_q, we_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            rdy_q, rdy_d;
  logic            vld_q, vld_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            fire_c;
  logic            size_bad_c;
  logic            range_bad_c;
  logic            req_err_c;
  logic [BAW-1:0]  req_baddr_c;
  logic [AW-1:0]   widx_c;
  logic [1:0]      boff_c;
  logic [3:0]      be_c;
  logic [31:0]     wlane_c;
  logic [31:0]     load_c;

  // Request decode: error classification and natural alignment of the byte address.
  always_comb begin
    fire_c      = bus.req_valid && (state_q == S_IDLE);
    size_bad_c  = (bus.req_size == 2'b11);
    range_bad_c = ((bus.req_addr >> BAW) != 32'd0);
    req_baddr_c = bus.req_addr[BAW-1:0];
    case (bus.req_size)
      2'b01:   req_baddr_c[0]   = 1'b0;
      2'b10:   req_baddr_c[1:0] = 2'b00;
      default: ;
    endcase
`ifdef DMEM_MISALIGN_TRAP_EN
    req_err_c = size_bad_c || range_bad_c ||
                ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
    req_err_c = size_bad_c || range_bad_c;
`endif
  end

  // Store lane steering and right-aligned load extraction for the latched request.
  always_comb begin
    widx_c = addr_q[BAW-1:2];
    boff_c = addr_q[1:0];
    case (size_q)
      2'b00: begin
        be_c    = 4'b0001 << boff_c;
        wlane_c = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be_c    = boff_c[1] ? 4'b1100 : 4'b0011;
        wlane_c = {2{wdata_q[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wlane_c = wdata_q;
      end
    endcase
    load_c = mem[widx_c] >> {boff_c, 3'b000};
  end

  // Word array; the store commits at the edge that ends ACCESS.
  always_ff @(posedge clk) begin
    if ((state_q == S_ACCESS) && we_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem[widx_c][8*i +: 8] <= wlane_c[8*i +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic, including the wait-state counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (fire_c) begin
          if (req_err_c) begin
            state_d = S_RESP;
          end else if (WAIT_CYCLES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CW'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_ACCESS;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output and request-latch next values; response fields only change on entry to RESP.
  always_comb begin
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdy_d   = (state_d == S_IDLE);
    vld_d   = (state_d == S_RESP);
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (fire_c) begin
          addr_d  = req_baddr_c;
          size_d  = bus.req_size;
          we_d    = bus.req_we;
          wdata_d = bus.req_wdata;
          if (req_err_c) begin
            err_d   = 1'b1;
            rdata_d = 32'd0;
          end
        end
      end
      S_ACCESS: begin
        err_d   = 1'b0;
        rdata_d = we_q ? 32'd0 : load_c;
      end
      default: ;
    endcase
  end

  // Request latch and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      size_q  <= 2'b00;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.req_ready = rdy_q;
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: byte-addressed reference model checked every cycle,
// plus directed scenarios with literal expectations and a randomized request stream.
module tb_data_mem_responder;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned W     = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  data_mem_responder_if bus();

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: byte-addressed memory and a schedule of the single outstanding response.
  logic [7:0]  bmem [DEPTH*4];
  int          cyc = 0;
  int          free_cyc = 0;
  int          resp_cyc = 0;
  bit          pend = 0;
  logic        pend_er = 1'b0;
  logic [31:0] pend_rd = 32'd0;
  bit          st_pend = 0;
  logic [31:0] st_a = 32'd0;
  logic [1:0]  st_sz = 2'd0;
  logic [31:0] st_wd = 32'd0;
  logic [31:0] last_rd = 32'd0;
  logic        last_er = 1'b0;

  function automatic logic [31:0] mword(input logic [31:0] a);
    int unsigned b;
    b = int'(a) & ~3;
    return {bmem[b+3], bmem[b+2], bmem[b+1], bmem[b]};
  endfunction

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    logic        e;
    bit          exp_valid;
    int          nbytes;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        pend     = 0;
        st_pend  = 0;
        last_rd  = 32'd0;
        last_er  = 1'b0;
        free_cyc = cyc;
      end
      exp_valid = pend && (cyc == resp_cyc);
      if (exp_valid) begin
        last_rd = pend_rd;
        last_er = pend_er;
        if (st_pend) begin
          nbytes = (st_sz == 2'd0) ? 1 : (st_sz == 2'd1) ? 2 : 4;
          for (int i = 0; i < nbytes; i++) bmem[int'(st_a) + i] = st_wd[8*i +: 8];
        end
        pend    = 0;
        st_pend = 0;
      end
      chk("req_ready", 32'(bus.req_ready), 32'(cyc >= free_cyc));
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
      chk("rsp_rdata", bus.rsp_rdata, last_rd);
      chk("rsp_err",   32'(bus.rsp_err), 32'(last_er));
      if (!reset && bus.req_valid && (cyc >= free_cyc)) begin
        a  = bus.req_addr;
        sz = bus.req_size;
        e  = (sz == 2'b11) || (a >= 32'(DEPTH*4));
`ifdef DMEM_MISALIGN_TRAP_EN
        e  = e || ((sz == 2'b01) && a[0]) || ((sz == 2'b10) && (a[1:0] != 2'b00));
`endif
        if (sz == 2'b01) a[0] = 1'b0;
        else if (sz == 2'b10) a[1:0] = 2'b00;
        pend     = 1;
        pend_er  = e;
        st_pend  = !e && bus.req_we;
        st_a     = a;
        st_sz    = sz;
        st_wd    = bus.req_wdata;
        pend_rd  = (e || bus.req_we) ? 32'd0 : (mword(a) >> (8 * int'(a[1:0])));
        resp_cyc = cyc + (e ? 1 : 2 + int'(W));
        free_cyc = resp_cyc + 1;
      end
    end
  end

  task automatic send(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_size  = sz;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout: waited %0d cycles, required under 50", n);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_size  = 2'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
  endtask

  task automatic wait_rsp(output logic [31:0] rd, output logic er, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 50);
    if (!bus.rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL response_timeout: no rsp_valid within %0d cycles", lat);
    end
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    send(we, sz, a, wd);
    wait_rsp(rd, er, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          r;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] a;

    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'b00;
    bus.req_addr  = 32'd0;
    bus.req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    do_req(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, rd, er, lat);
    chk("sw_lat", 32'(lat), 32'd3);
    chk("sw_err", 32'(er), 32'd0);
    chk("sw_rdata", rd, 32'd0);
    do_req(1'b0, 2'b10, 32'h10, 32'h0, rd, er, lat);
    chk("lw_10", rd, 32'hDEADBEEF);
    chk("lw_lat", 32'(lat), 32'd3);

    do_req(1'b1, 2'b00, 32'h12, 32'hAAAAAA55, rd, er, lat);
    do_req(1'b0, 2'b10, 32'h10, 32'h0, rd, er, lat);
    chk("lw_after_sb", rd, 32'hDE55BEEF);
    do_req(1'b0, 2'b00, 32'h13, 32'h0, rd, er, lat);
    chk("lb_13", rd, 32'h000000DE);

    do_req(1'b1, 2'b10, 32'h14, 32'h0, rd, er, lat);
    do_req(1'b1, 2'b01, 32'h16, 32'h1234A5A5, rd, er, lat);
    do_req(1'b0, 2'b10, 32'h14, 32'h0, rd, er, lat);
    chk("lw_after_sh", rd, 32'hA5A50000);
    do_req(1'b0, 2'b01, 32'h16, 32'h0, rd, er, lat);
    chk("lh_16", rd, 32'h0000A5A5);

    do_req(1'b0, 2'b10, 32'h11, 32'h0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("lw_11_err", 32'(er), 32'd1);
    chk("lw_11_rdata", rd, 32'd0);
    chk("lw_11_lat", 32'(lat), 32'd1);
`else
    chk("lw_11_err", 32'(er), 32'd0);
    chk("lw_11_rdata", rd, 32'hDE55BEEF);
    chk("lw_11_lat", 32'(lat), 32'd3);
`endif

    do_req(1'b1, 2'b10, 32'h0, 32'h11111111, rd, er, lat);
    do_req(1'b1, 2'b10, 32'h1000, 32'hCAFEF00D, rd, er, lat);
    chk("oor_err", 32'(er), 32'd1);
    chk("oor_lat", 32'(lat), 32'd1);
    do_req(1'b0, 2'b10, 32'h0, 32'h0, rd, er, lat);
    chk("word0_kept", rd, 32'h11111111);
    do_req(1'b0, 2'b11, 32'h10, 32'h0, rd, er, lat);
    chk("size11_err", 32'(er), 32'd1);
    chk("size11_rdata", rd, 32'd0);

    // Abort a store with reset while it sits in its wait state.
    do_req(1'b1, 2'b10, 32'h20, 32'h0, rd, er, lat);
    send(1'b1, 2'b10, 32'h20, 32'h12345678);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort_ready", 32'(bus.req_ready), 32'd1);
      chk("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    do_req(1'b0, 2'b10, 32'h20, 32'h0, rd, er, lat);
    chk("abort_no_write", rd, 32'h0);

    for (int i = 0; i < 64; i++) do_req(1'b1, 2'b10, 32'(i * 4), $urandom, rd, er, lat);

    for (int k = 0; k < 300; k++) begin
      r  = int'($urandom_range(0, 99));
      we = 1'($urandom);
      sz = (r < 5) ? 2'b11 : 2'($urandom_range(0, 2));
      if (r >= 5 && r < 10) a = $urandom | 32'h1000;
      else a = 32'($urandom_range(0, 255));
      do_req(we, sz, a, $urandom, rd, er, lat);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
